// File: rtl/img_filter_seq.sv
// Frame sequencer: streams a greyscale frame from a source RAM to a destination RAM in raster
// order. Each pixel is either copied or sent through an external 3x3 kernel engine.
// Border pixels are copied or replaced by a constant. A kernel timeout falls back to the centre
// pixel.
module img_filter_seq #(
    parameter int D_WIDTH  = 8,
    parameter int COL_BITS = 8,
    parameter int ROW_BITS = 8,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int WAIT_MAX = 64
) (
    input  logic                         CLK,
    input  logic                         NRST,
    input  logic                         START,
    input  logic                         MODE,
    input  logic                         BORDER_MODE,
    input  logic [D_WIDTH-1:0]           BORDER_VAL,
    output logic [ROW_BITS+COL_BITS-1:0] SRC_ADDR,
    input  logic [D_WIDTH-1:0]           SRC_Q,
    output logic                         DST_WREN,
    output logic [ROW_BITS+COL_BITS-1:0] DST_ADDR,
    output logic [D_WIDTH-1:0]           DST_DATA,
    output logic [D_WIDTH-1:0]           KER_DI,
    output logic                         KER_DSI,
    input  logic [D_WIDTH-1:0]           KER_DO,
    input  logic                         KER_DSO,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         ERR
);

    localparam int A_WIDTH = ROW_BITS + COL_BITS;
    localparam int WC_W    = $clog2(WAIT_MAX + 1);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_W - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_H - 1);
    localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
    localparam logic [WC_W-1:0]     WAIT_LIM = WC_W'(WAIT_MAX);
    localparam logic [WC_W-1:0]     WC_ONE   = WC_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StLoad,
        StWait,
        StKwr,
        StFin
    } state_t;

    state_t               r_state, w_state;
    logic [ROW_BITS-1:0]  r_row, w_row;
    logic [COL_BITS-1:0]  r_col, w_col;
    logic [3:0]           r_ld_cnt, w_ld_cnt;
    logic [WC_W-1:0]      r_wait_cnt, w_wait_cnt;
    logic [D_WIDTH-1:0]   r_centre, w_centre;
    logic [D_WIDTH-1:0]   r_result, w_result;
    logic                 r_err, w_err;
    logic                 r_mode, w_mode;
    logic                 r_bmode, w_bmode;
    logic [D_WIDTH-1:0]   r_bval, w_bval;
    logic [A_WIDTH-1:0]   r_src_addr, w_src_addr;

    logic                 w_cur_border;
    logic                 w_last_pix;
    logic [ROW_BITS-1:0]  w_adv_row;
    logic [COL_BITS-1:0]  w_adv_col;
    logic                 w_adv_border;

    // Neighbour k (0..8, raster within the 3x3 window) built from separate row/column terms so
    // no carry ever crosses from the column into the row field.
    function automatic logic [A_WIDTH-1:0] nbr_addr(input logic [ROW_BITS-1:0] row,
                                                    input logic [COL_BITS-1:0] col,
                                                    input logic [3:0]          k);
        logic [ROW_BITS-1:0] rr;
        logic [COL_BITS-1:0] cc;
        case (k)
            4'd0, 4'd1, 4'd2: rr = row - ROW_ONE;
            4'd6, 4'd7, 4'd8: rr = row + ROW_ONE;
            default:          rr = row;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: cc = col - COL_ONE;
            4'd2, 4'd5, 4'd8: cc = col + COL_ONE;
            default:          cc = col;
        endcase
        return {rr, cc};
    endfunction

    // Current-pixel classification and the raster successor.
    always_comb begin
        w_cur_border = (r_row == '0) || (r_row == LAST_ROW) ||
                       (r_col == '0) || (r_col == LAST_COL);
        w_last_pix   = (r_row == LAST_ROW) && (r_col == LAST_COL);
        w_adv_col    = (r_col == LAST_COL) ? '0 : r_col + COL_ONE;
        w_adv_row    = (r_col == LAST_COL) ? r_row + ROW_ONE : r_row;
        w_adv_border = (w_adv_row == '0) || (w_adv_row == LAST_ROW) ||
                       (w_adv_col == '0) || (w_adv_col == LAST_COL);
    end

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        w_state    = r_state;
        w_row      = r_row;
        w_col      = r_col;
        w_ld_cnt   = r_ld_cnt;
        w_wait_cnt = r_wait_cnt;
        w_centre   = r_centre;
        w_result   = r_result;
        w_err      = r_err;
        w_mode     = r_mode;
        w_bmode    = r_bmode;
        w_bval     = r_bval;
        case (r_state)
            StIdle: begin
                if (START) begin
                    w_mode  = MODE;
                    w_bmode = BORDER_MODE;
                    w_bval  = BORDER_VAL;
                    w_err   = 1'b0;
                    w_row   = '0;
                    w_col   = '0;
                    // (0,0) is always a border pixel.
                    w_state = StRd;
                end
            end
            StRd: w_state = StWr;
            StLoad: begin
                // SRC_Q in cycle 5 is the data for the centre address issued in cycle 4.
                if (r_ld_cnt == 4'd5) begin
                    w_centre = SRC_Q;
                end
                if (r_ld_cnt == 4'd9) begin
                    w_state    = StWait;
                    w_wait_cnt = WC_ONE;
                end else begin
                    w_ld_cnt = r_ld_cnt + 4'd1;
                end
            end
            StWait: begin
                if (KER_DSO) begin
                    w_result = KER_DO;
                    w_state  = StKwr;
                end else if (r_wait_cnt == WAIT_LIM) begin
                    w_err    = 1'b1;
                    w_result = r_centre;
                    w_state  = StKwr;
                end else begin
                    w_wait_cnt = r_wait_cnt + WC_ONE;
                end
            end
            StWr, StKwr: begin
                if (w_last_pix) begin
                    w_state = StFin;
                end else begin
                    w_row = w_adv_row;
                    w_col = w_adv_col;
                    if (!r_mode || w_adv_border) begin
                        w_state = StRd;
                    end else begin
                        w_state  = StLoad;
                        w_ld_cnt = 4'd0;
                    end
                end
            end
            StFin:   w_state = StIdle;
            default: w_state = StIdle;
        endcase
    end

    // Source address is registered: it is set up for the state being entered.
    always_comb begin
        w_src_addr = r_src_addr;
        if (w_state == StRd) begin
            w_src_addr = {w_row, w_col};
        end else if (w_state == StLoad) begin
            w_src_addr = nbr_addr(w_row, w_col, w_ld_cnt);
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state    <= StIdle;
            r_row      <= '0;
            r_col      <= '0;
            r_ld_cnt   <= '0;
            r_wait_cnt <= '0;
            r_centre   <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_mode     <= 1'b0;
            r_bmode    <= 1'b0;
            r_bval     <= '0;
            r_src_addr <= '0;
        end else begin
            r_state    <= w_state;
            r_row      <= w_row;
            r_col      <= w_col;
            r_ld_cnt   <= w_ld_cnt;
            r_wait_cnt <= w_wait_cnt;
            r_centre   <= w_centre;
            r_result   <= w_result;
            r_err      <= w_err;
            r_mode     <= w_mode;
            r_bmode    <= w_bmode;
            r_bval     <= w_bval;
            r_src_addr <= w_src_addr;
        end
    end

    // Outputs decoded from the state; everything idles at zero.
    always_comb begin
        SRC_ADDR = r_src_addr;
        DST_WREN = 1'b0;
        DST_ADDR = '0;
        DST_DATA = '0;
        KER_DI   = '0;
        KER_DSI  = 1'b0;
        BUSY     = (r_state != StIdle) && (r_state != StFin);
        DONE     = (r_state == StFin);
        ERR      = r_err;
        case (r_state)
            StWr: begin
                DST_WREN = 1'b1;
                DST_ADDR = {r_row, r_col};
                DST_DATA = (w_cur_border && r_bmode) ? r_bval : SRC_Q;
            end
            StKwr: begin
                DST_WREN = 1'b1;
                DST_ADDR = {r_row, r_col};
                DST_DATA = r_result;
            end
            StLoad: begin
                if (r_ld_cnt != 4'd0) begin
                    KER_DSI = 1'b1;
                    KER_DI  = SRC_Q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_img_filter_seq.sv
// Bench for img_filter_seq on a 4x4 frame: source RAM holds src[a]=a, a kernel model returns
// the max of its nine inputs three cycles after the last strobe (or never, when disabled).
module tb_img_filter_seq;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          NRST;
    logic          START;
    logic          MODE;
    logic          BORDER_MODE;
    logic [DW-1:0] BORDER_VAL;
    logic [AW-1:0] SRC_ADDR;
    logic [DW-1:0] SRC_Q;
    logic          DST_WREN;
    logic [AW-1:0] DST_ADDR;
    logic [DW-1:0] DST_DATA;
    logic [DW-1:0] KER_DI;
    logic          KER_DSI;
    logic [DW-1:0] KER_DO;
    logic          KER_DSO;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    img_filter_seq #(
        .D_WIDTH  (DW),
        .COL_BITS (2),
        .ROW_BITS (2),
        .IMG_W    (4),
        .IMG_H    (4),
        .WAIT_MAX (16)
    ) dut (
        .CLK         (CLK),
        .NRST        (NRST),
        .START       (START),
        .MODE        (MODE),
        .BORDER_MODE (BORDER_MODE),
        .BORDER_VAL  (BORDER_VAL),
        .SRC_ADDR    (SRC_ADDR),
        .SRC_Q       (SRC_Q),
        .DST_WREN    (DST_WREN),
        .DST_ADDR    (DST_ADDR),
        .DST_DATA    (DST_DATA),
        .KER_DI      (KER_DI),
        .KER_DSI     (KER_DSI),
        .KER_DO      (KER_DO),
        .KER_DSO     (KER_DSO),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    // Source RAM, one-cycle synchronous read.
    always @(posedge CLK) SRC_Q <= SRC_ADDR;

    // Kernel model.
    bit            ken;
    int            k_cnt;
    int            k_tmr;
    logic [DW-1:0] k_max;
    always @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            k_cnt   <= 0;
            k_tmr   <= 0;
            k_max   <= '0;
            KER_DSO <= 1'b0;
            KER_DO  <= '0;
        end else begin
            KER_DSO <= 1'b0;
            if (k_tmr != 0) begin
                k_tmr <= k_tmr - 1;
                if (k_tmr == 1 && ken) begin
                    KER_DSO <= 1'b1;
                    KER_DO  <= k_max;
                end
            end
            if (KER_DSI) begin
                k_max <= (k_cnt == 0 || KER_DI > k_max) ? KER_DI : k_max;
                if (k_cnt == 8) begin
                    k_cnt <= 0;
                    k_tmr <= 3;
                end else begin
                    k_cnt <= k_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            interior;
    } wr_t;

    typedef struct {
        bit            mode;
        bit            bmode;
        logic [DW-1:0] bval;
        bit            ken;
        int            mid_start;
    } cfg_t;

    wr_t  sb[$];
    int   dsi_log[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   cyc = 0;
    int   n_wr;
    int   done_seen;
    int   last_wr;
    int   last_dsi;
    int   lat_exp;
    bit   tmo_frame;
    bit   err_model;
    bit   prev_wren;
    bit   saw_dsi;
    cfg_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Sample all DUT outputs at the falling edge and score them.
    task automatic sample_cycle();
        wr_t e;
        @(negedge CLK);
        cyc++;
        saw_dsi = 1'b0;
        if (DST_WREN) begin
            chk("wren_not_back_to_back", 32'(prev_wren), 32'd0);
            if (sb.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                e = sb.pop_front();
                chk("dst_addr", 32'(DST_ADDR), 32'(e.addr));
                chk("dst_data", 32'(DST_DATA), 32'(e.data));
                if (tmo_frame && e.interior) err_model = 1'b1;
                chk("err_at_write", 32'(ERR), 32'(err_model));
                if (lat_exp != 0 && e.interior)
                    chk("timeout_latency", 32'(cyc - last_dsi), 32'(lat_exp));
            end
            last_wr = cyc;
            n_wr++;
        end
        prev_wren = DST_WREN;
        if (KER_DSI) begin
            dsi_log.push_back(int'(KER_DI));
            last_dsi = cyc;
            saw_dsi  = 1'b1;
        end
        if (DONE) begin
            done_seen++;
            chk("busy_low_at_done", 32'(BUSY), 32'd0);
            chk("done_after_last_write", 32'(cyc - last_wr), 32'd1);
            chk("scoreboard_empty_at_done", 32'(sb.size()), 32'd0);
        end
    endtask

    // Push the expected frame and pulse START.
    task automatic launch(input cfg_t cfg);
        int  d;
        int  a;
        bit  border;
        wr_t e;
        sb.delete();
        dsi_log.delete();
        n_wr      = 0;
        done_seen = 0;
        ken       = cfg.ken;
        tmo_frame = cfg.mode && !cfg.ken;
        lat_exp   = tmo_frame ? 17 : 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a      = r * 4 + c;
                border = (r == 0) || (r == 3) || (c == 0) || (c == 3);
                if (border)        d = cfg.bmode ? int'(cfg.bval) : a;
                else if (!cfg.mode) d = a;
                else if (cfg.ken)  d = (r + 1) * 4 + c + 1;
                else               d = a;
                e.addr     = AW'(a);
                e.data     = DW'(d);
                e.interior = !border;
                sb.push_back(e);
            end
        end
        MODE        = cfg.mode;
        BORDER_MODE = cfg.bmode;
        BORDER_VAL  = cfg.bval;
        START       = 1'b1;
        err_model   = 1'b0;
        sample_cycle();
        START       = 1'b0;
        chk("busy_after_start", 32'(BUSY), 32'd1);
        chk("err_cleared_on_start", 32'(ERR), 32'd0);
    endtask

    task automatic run_frame(input cfg_t cfg);
        int i;
        int k;
        launch(cfg);
        i = 0;
        while (done_seen == 0 && i < 2000) begin
            START = (cfg.mid_start != 0 && i == cfg.mid_start);
            sample_cycle();
            i++;
        end
        START = 1'b0;
        if (done_seen == 0) fail_now("frame_done_timeout");
        repeat (4) sample_cycle();
        chk("write_count", 32'(n_wr), 32'd16);
        chk("done_count", 32'(done_seen), 32'd1);
        chk("dsi_count", 32'(dsi_log.size()), cfg.mode ? 32'd36 : 32'd0);
        if (cfg.mode && dsi_log.size() == 36) begin
            k = 0;
            for (int r = 1; r < 3; r++)
                for (int c = 1; c < 3; c++)
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            chk("dsi_data_order", 32'(dsi_log[k]),
                                32'((r + dr) * 4 + c + dc));
                            k++;
                        end
        end
        chk("err_after_frame", 32'(ERR), 32'(tmo_frame));
    endtask

    initial begin
        int i;
        tbl[0] = '{mode: 1'b0, bmode: 1'b0, bval: 8'h00, ken: 1'b1, mid_start: 0};
        tbl[1] = '{mode: 1'b1, bmode: 1'b0, bval: 8'h00, ken: 1'b1, mid_start: 0};
        tbl[2] = '{mode: 1'b1, bmode: 1'b1, bval: 8'hAA, ken: 1'b1, mid_start: 0};
        tbl[3] = '{mode: 1'b1, bmode: 1'b0, bval: 8'h00, ken: 1'b0, mid_start: 0};
        tbl[4] = '{mode: 1'b0, bmode: 1'b1, bval: 8'h55, ken: 1'b1, mid_start: 0};
        tbl[5] = '{mode: 1'b1, bmode: 1'b0, bval: 8'h00, ken: 1'b1, mid_start: 30};

        NRST        = 1'b0;
        START       = 1'b0;
        MODE        = 1'b0;
        BORDER_MODE = 1'b0;
        BORDER_VAL  = '0;
        ken         = 1'b1;
        prev_wren   = 1'b0;
        last_wr     = 0;
        last_dsi    = 0;
        tmo_frame   = 1'b0;
        lat_exp     = 0;
        err_model   = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_ctrl", 32'({DST_WREN, KER_DSI, BUSY, DONE, ERR}), 32'd0);
        chk("reset_src_addr", 32'(SRC_ADDR), 32'd0);
        chk("reset_dst", 32'({DST_ADDR, DST_DATA, KER_DI}), 32'd0);
        NRST = 1'b1;
        repeat (2) sample_cycle();

        for (int t = 0; t < 6; t++) run_frame(tbl[t]);

        // Reset during the LOAD of pixel (1,1), then a clean rerun.
        launch(tbl[1]);
        i = 0;
        while (!saw_dsi && i < 200) begin
            sample_cycle();
            i++;
        end
        if (!saw_dsi) fail_now("no_load_before_reset");
        chk("writes_before_reset", 32'(n_wr), 32'd5);
        NRST = 1'b0;
        #1;
        chk("midreset_ctrl", 32'({DST_WREN, KER_DSI, BUSY, DONE, ERR}), 32'd0);
        chk("midreset_src_addr", 32'(SRC_ADDR), 32'd0);
        chk("midreset_dst", 32'({DST_ADDR, DST_DATA, KER_DI}), 32'd0);
        sb.delete();
        repeat (3) sample_cycle();
        chk("no_write_in_reset", 32'(n_wr), 32'd5);
        NRST = 1'b1;
        repeat (2) sample_cycle();
        run_frame(tbl[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/img_filter_seq.md
Name: img_filter_seq

Overview:
- Parametrised frame-processing sequencer. Streams an IMG_W x IMG_H greyscale frame from a source image memory to a destination image memory in raster order.
- Per-frame mode selects plain copy or 3x3 neighbourhood filtering through an external kernel engine (median or similar) with a DSI/DSO handshake.
- Border pixels are handled by a selectable policy. Adds start/busy/done control and a kernel-timeout error path.
- Sits between the source image RAM, the kernel engine and the result RAM feeding VGA readout.

Parameters:
- D_WIDTH, 8: pixel width.
- COL_BITS, 8: column address bits; A_WIDTH = ROW_BITS+COL_BITS.
- ROW_BITS, 8: row address bits.
- IMG_W, 256: active columns, 3 ≤ IMG_W ≤ 2^COL_BITS.
- IMG_H, 256: active rows, 3 ≤ IMG_H ≤ 2^ROW_BITS.
- WAIT_MAX, 64: max cycles to wait for KER_DSO before timeout.

Ports:
- CLK  in  1  clock
- NRST  in  1  asynchronous active-low reset
- START  in  1  one-cycle frame start request
- MODE  in  1  0 = copy, 1 = filter; sampled at accepted START
- BORDER_MODE  in  1  0 = copy source pixel, 1 = write BORDER_VAL; sampled at START
- BORDER_VAL  in  D_WIDTH  constant border value; sampled at START
- SRC_ADDR  out  A_WIDTH  source read address, registered
- SRC_Q  in  D_WIDTH  source read data, valid the cycle after SRC_ADDR changes (1-cycle sync RAM)
- DST_WREN  out  1  destination write strobe
- DST_ADDR  out  A_WIDTH  destination address
- DST_DATA  out  D_WIDTH  destination data
- KER_DI  out  D_WIDTH  kernel data in
- KER_DSI  out  1  kernel data strobe
- KER_DO  in  D_WIDTH  kernel result
- KER_DSO  in  1  kernel result strobe
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse, frame complete
- ERR  out  1  sticky kernel timeout flag

Behaviour:
- Addressing: pixel (r,c) → address {r[ROW_BITS-1:0], c[COL_BITS-1:0]}. Raster order: c increments 0..IMG_W-1, then r increments. Frame ends after (IMG_H-1, IMG_W-1). No wrap into a second frame.
- Reset: all outputs 0, state IDLE, pixel counters 0. Asynchronous and effective mid-frame; no partial write completes after NRST falls.
- States: IDLE, RD, WR, LOAD, WAIT, KWR, FIN.
- IDLE:
  - START=1 → latch MODE, BORDER_MODE and BORDER_VAL; clear ERR; set BUSY=1; select the path for pixel (0,0).
  - START while BUSY is ignored.
- Path select per pixel: border if r==0, r==IMG_H-1, c==0 or c==IMG_W-1. Copy path if MODE==0 or border; else filter path.
- Copy path:
  - RD: SRC_ADDR = pixel address, 1 cycle.
  - WR: DST_WREN=1 with DST_ADDR = pixel address. DST_DATA = SRC_Q, or BORDER_VAL if border and BORDER_MODE==1.
  - Then advance. Exactly 2 cycles per pixel.
- Filter path, LOAD (10 cycles):
  - SRC_ADDR sequence on cycles 0..8: (r-1,c-1), (r-1,c), (r-1,c+1), (r,c-1), (r,c), (r,c+1), (r+1,c-1), (r+1,c), (r+1,c+1).
  - KER_DSI=1 on cycles 1..9 with KER_DI = SRC_Q, giving exactly 9 consecutive strobes.
  - The centre SRC_Q value is captured for fallback.
- WAIT: counts cycles from 1. On KER_DSO=1, capture KER_DO → KWR. KER_DSO outside WAIT is ignored. If the count reaches WAIT_MAX without DSO → ERR=1 and use the captured centre pixel → KWR.
- KWR: DST_WREN=1, DST_ADDR = pixel address, DST_DATA = captured value. Then advance.
- Advance: after the last pixel → FIN. FIN: DONE=1 for one cycle, BUSY=0 in the same cycle → IDLE.
- DST_WREN is never high for more than one consecutive cycle. Each address is written exactly once per frame.
- ERR stays set until the next accepted START or reset.
- Arithmetic: neighbour addresses are formed from separate row/column counters, never by linear address offset. No carries across row boundaries.

Test Plan:
- Copy: bench COL_BITS=ROW_BITS=2, IMG_W=IMG_H=4, src[a]=a, MODE=0, START → 16 DST_WREN pulses to addresses 0..15 with data=address; DONE 1 cycle after the last write; BUSY low with DONE.
- Filter: MODE=1, BORDER_MODE=0, kernel model returns the max of 9 inputs after 3 cycles. Pixel (1,1) shows KER_DSI addresses 0,1,2,4,5,6,8,9,10 in order, and dst[5]=10. Dst at 6, 9 and 10 gets 11, 14 and 15. The 12 border pixels are copied.
- Border constant: MODE=1, BORDER_MODE=1, BORDER_VAL=8'hAA → addresses 0-4, 7, 8, 11-15 written 8'hAA; interior from the kernel.
- Timeout: WAIT_MAX=16, kernel never asserts DSO → each interior pixel written with its source centre value 16 cycles after LOAD; ERR=1 after the first timeout; ERR clears on the next START.
- Reset mid-LOAD: NRST low during pixel (1,1) LOAD → all outputs 0 immediately, no write to address 5. After release, START reruns from address 0 and produces the full correct frame.
- START while BUSY: second START pulse mid-frame → no restart and no counter change; exactly one DONE and 16 writes.
